// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver producing the toggle-strobe ps2_key event bus
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic [3:0]    filt_cnt_q;
    logic          clk_s;
    logic          din;
    logic          filt_hit;
    logic          fall;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_err_q, par_err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   key_q, key_d;
    logic          err;
    logic          ignore_byte;

    assign clk_s    = clk_sync_q[1];
    assign din      = dat_sync_q[1];
    assign filt_hit = (clk_s != filt_q) && (filt_cnt_q == 4'(FILTER_LEN - 1));
    // A fall is the cycle in which the filtered clock is about to drop from 1 to 0
    assign fall     = filt_hit && filt_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= 4'd0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            if (clk_s == filt_q) begin
                filt_cnt_q <= 4'd0;
            end else if (filt_hit) begin
                filt_q     <= clk_s;
                filt_cnt_q <= 4'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_err_q  <= 1'b0;
            to_cnt_q   <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= 8'd0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= 3'd0;
            key_q      <= 11'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            to_cnt_q   <= to_cnt_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            skip_q     <= skip_d;
            key_q      <= key_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        to_cnt_d   = to_cnt_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        err        = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                        par_err_d = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_err_d = ~(^shift_q ^ din);
                    state_d   = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (din && !par_err_q) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        err = 1'b1;
                    end
                end
            endcase
        end else if (state_q != S_IDLE) begin
            // The fall branch above takes precedence, so a coincident fall never times out
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d  = S_IDLE;
                err      = 1'b1;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    always_comb begin
        ignore_byte = 1'b0;
        case (byte_q)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ignore_byte = 1'b1;
            default: ignore_byte = 1'b0;
        endcase
    end

    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        key_d  = key_q;
        if (err) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = 3'd0;
        end else if (byte_vld_q) begin
            // Pause (E1) is followed by seven bytes that carry no key meaning
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (byte_q == 8'hE1) begin
                skip_d = 3'd7;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                rel_d = 1'b1;
            end else if (ignore_byte) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else begin
                key_d = {~key_q[10], ~rel_q, ext_q, byte_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err;

endmodule
